proc_axil_loader: RTL
=====================

# proc_axil_loader

AXI4-Lite subordinate that lets the PS/host own the processor's memory-side back doors. It drives the instruction-memory write port (program load) and the data-memory B port (host read/write of shared data), and optionally holds the core in reset while loading. It sits between the PS interconnect and the `pipelined_processor` top, alongside the core. One FSM serialises all transactions.

## Interface
- `WIDTH`, 32, data word width; only 32 is supported.
- `SIZE`, 64, words per memory; `LOGSIZE = $clog2(SIZE)`.
- `NUM_COL`, 4, byte lanes per word.
- `COL_WIDTH`, 8, bits per lane.
- `ADDR_W` (localparam), `LOGSIZE+4`, AXI byte-address width.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `s_awaddr`  in  ADDR_W  write address. `s_awvalid` in 1. `s_awready` out 1.
- `s_wdata`  in  WIDTH  write data. `s_wstrb` in NUM_COL. `s_wvalid` in 1. `s_wready` out 1.
- `s_bresp`  out  2  write response. `s_bvalid` out 1. `s_bready` in 1.
- `s_araddr`  in  ADDR_W  read address. `s_arvalid` in 1. `s_arready` out 1.
- `s_rdata`  out  WIDTH  read data. `s_rresp` out 2. `s_rvalid` out 1. `s_rready` in 1.
- `instr_in`  out  WIDTH  data to the instruction memory.
- `instr_wr_addr`  out  LOGSIZE+2  byte address to the instruction memory.
- `instr_wr_en`  out  1  instruction-memory write strobe.
- `dmem_data_in`  out  WIDTH  to the core's `AXI_dmem_data_in`.
- `dmem_data_out`  in  WIDTH  from the core's `AXI_dmem_data_out`.
- `dmem_word_addr`  out  LOGSIZE  word address to data-memory port B.
- `dmem_byte_wr_en`  out  NUM_COL  byte write enables for port B.
- `core_reset`  out  1  reset to drive the processor.

## Operation
- Address decode uses `addr[LOGSIZE+3:LOGSIZE+2]`:
  - 00: data memory, word = `addr[LOGSIZE+1:2]`.
  - 01: instruction memory, write-only.
  - 10: control register.
  - 11: reserved.
- The low two address bits are ignored.
- FSM states are IDLE, WR_RESP, RD_ISSUE, RD_CAPTURE and RD_RESP.
- IDLE, write:
  - The write is taken only when `s_awvalid` and `s_wvalid` are both high.
  - `s_awready` and `s_wready` are asserted together for exactly that cycle (combinational in IDLE). Next state is WR_RESP.
- IDLE, read:
  - Taken when `s_arvalid` is high and no write is taken that cycle. Write has priority.
  - `s_arready` is high for that one cycle. Next state is RD_ISSUE.
- Write effects, registered and applied on the first WR_RESP cycle only:
  - Data memory: `dmem_byte_wr_en = s_wstrb`, `dmem_data_in = s_wdata`. Response OKAY.
  - Instruction memory with `s_wstrb == 4'hF`: `instr_wr_en = 1` for one cycle, `instr_wr_addr` = byte address, `instr_in = s_wdata`. Response OKAY.
  - Instruction memory with any other strobe: no write. Response SLVERR (2'b10).
  - Control register: bit0 is written from `s_wdata[0]` when `s_wstrb[0]` is set. Response OKAY.
  - Reserved region: no effect. Response SLVERR.
- WR_RESP: `s_bvalid` stays high until `s_bready`, then the FSM returns to IDLE.
- Read path:
  - RD_ISSUE drives `dmem_word_addr`.
  - RD_CAPTURE samples `dmem_data_out`; port B has 1-cycle read latency.
  - RD_RESP holds `s_rvalid` and `s_rdata` until `s_rready`.
- Read responses:
  - Instruction-memory region: `s_rdata = 0`, SLVERR.
  - Reserved region: `s_rdata = 0`, SLVERR.
  - Control register: `{31'b0, ctrl[0]}`, OKAY.
- Address outputs and `dmem_data_in` hold their last value when idle. The strobes are 0 except on the single effect cycle.

## Timing
- Reset values: all ready/valid outputs 0, resp 0, `s_rdata` 0, strobes 0, address and data outputs 0. FSM returns to IDLE. `ctrl[0]` is 1.
- Write: handshake in cycle N. The strobe and `s_bvalid` rise in cycle N+1. Earliest next handshake is N+2, when `s_bready` is already high.
- Read: handshake in cycle N. Address is driven in N+1, data captured in N+2, `s_rvalid` rises in N+3.
- AW without W, or W without AW: nothing is accepted. The bridge waits for both.
- Simultaneous AW/W and AR in IDLE: the write is served first. The AR stays pending and is taken in the first IDLE cycle after `s_bready`.
- Asserting `reset` in any state aborts the transaction immediately:
  - No strobe is issued after the reset cycle.
  - The valid outputs drop the next cycle.
  - The host must reissue the transaction.
- Back-pressure: `s_bready` and `s_rready` low holds the state indefinitely. The response stays stable.

## Configuration
- `PROC_LOADER_CTRL_EN` defined:
  - The control register exists.
  - `core_reset = reset | ctrl[0]`, so the core is held in reset after `reset` until the host writes 0.
- Not defined:
  - Region 10 behaves like reserved: SLVERR, no effect.
  - `core_reset = reset`.

## Test plan
- Write 0xDEADBEEF, strobe 0xF, to addr 0x004 -> `dmem_byte_wr_en = 0xF` and `dmem_word_addr = 1` for exactly one cycle at N+1; `s_bresp = 0`. A read of 0x004 then returns 0xDEADBEEF at N+3 with OKAY.
- Write 0x00000013 to the instruction region, byte offset 0x08, strobe 0xF -> `instr_wr_en` pulses once with `instr_wr_addr = 0x08`; OKAY. Repeat with strobe 0x3 -> no `instr_wr_en`; `s_bresp = 2'b10`.
- Write 0x000000AA, strobe 0x1, to data word 2, which was 0x11223344 -> `dmem_byte_wr_en = 0x1`; a readback returns 0x112233AA.
- AW/W and AR valid in the same cycle -> `s_awready` first, `s_arready` only after the B handshake. `s_bready` held low for 5 cycles -> `s_bvalid` stable throughout.
- With `PROC_LOADER_CTRL_EN`: after reset `core_reset = 1`. Write 0 to the control register -> `core_reset = 0` from N+1; reading it returns 0x0. Without the macro the same write gets SLVERR.
- Assert `reset` during RD_CAPTURE -> `s_rvalid` never rises and all outputs return to their reset values.

Source files
------------

// File: rtl/proc_axil_loader_if.sv
// AXI4-Lite bus between the PS interconnect (master) and the processor loader (slave).
// Carries the five AXI4-Lite channels only; clock and reset stay plain ports.
interface proc_axil_loader_if #(
   parameter int ADDR_W  = 10,
   parameter int WIDTH   = 32,
   parameter int NUM_COL = 4
);
   logic [ADDR_W-1:0]  s_awaddr;
   logic               s_awvalid;
   logic               s_awready;
   logic [WIDTH-1:0]   s_wdata;
   logic [NUM_COL-1:0] s_wstrb;
   logic               s_wvalid;
   logic               s_wready;
   logic [1:0]         s_bresp;
   logic               s_bvalid;
   logic               s_bready;
   logic [ADDR_W-1:0]  s_araddr;
   logic               s_arvalid;
   logic               s_arready;
   logic [WIDTH-1:0]   s_rdata;
   logic [1:0]         s_rresp;
   logic               s_rvalid;
   logic               s_rready;

   modport slave (
      input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
      input  s_araddr, s_arvalid, s_rready,
      output s_awready, s_wready, s_bresp, s_bvalid,
      output s_arready, s_rdata, s_rresp, s_rvalid
   );

   modport master (
      output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
      output s_araddr, s_arvalid, s_rready,
      input  s_awready, s_wready, s_bresp, s_bvalid,
      input  s_arready, s_rdata, s_rresp, s_rvalid
   );
endinterface

// File: rtl/proc_axil_loader.sv
// AXI4-Lite back door to imem write port, dmem port B and (with PROC_LOADER_CTRL_EN) a core-reset ctrl bit.
// Latency: write effect + B at N+1 after AW/W handshake; R at N+3 after AR handshake (port B read latency 1).
// Backpressure: one transaction at a time; B/R held stable until bready/rready, new requests wait in IDLE.
module proc_axil_loader #(
   parameter int WIDTH     = 32,
   parameter int SIZE      = 64,
   parameter int NUM_COL   = 4,
   parameter int COL_WIDTH = 8,
   localparam int LOGSIZE  = $clog2(SIZE),
   localparam int ADDR_W   = LOGSIZE + 4
) (
   input  logic                 clk,
   input  logic                 reset,
   proc_axil_loader_if.slave    s,
   output logic [WIDTH-1:0]     instr_in,
   output logic [LOGSIZE+1:0]   instr_wr_addr,
   output logic                 instr_wr_en,
   output logic [WIDTH-1:0]     dmem_data_in,
   input  logic [WIDTH-1:0]     dmem_data_out,
   output logic [LOGSIZE-1:0]   dmem_word_addr,
   output logic [NUM_COL-1:0]   dmem_byte_wr_en,
   output logic                 core_reset
);
   typedef enum logic [2:0] {IDLE, WR_RESP, RD_ISSUE, RD_CAPTURE, RD_RESP} state_e;
   typedef enum logic [1:0] {REG_DMEM = 2'b00, REG_IMEM = 2'b01, REG_CTRL = 2'b10, REG_RSVD = 2'b11} region_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   state_e  state, state_nxt;
   region_e aw_region, ar_region, rd_region;
   logic    wr_take, rd_take;
   logic [1:0]       bresp, rresp;
   logic [WIDTH-1:0] rdata;
   logic [ADDR_W-1:0] awaddr, araddr;
   logic [NUM_COL-1:0][COL_WIDTH-1:0] wr_lanes;
   logic unused_addr_lsbs;

   assign awaddr    = s.s_awaddr;
   assign araddr    = s.s_araddr;
   assign wr_lanes  = s.s_wdata;
   assign aw_region = region_e'(awaddr[LOGSIZE+3:LOGSIZE+2]);
   assign ar_region = region_e'(araddr[LOGSIZE+3:LOGSIZE+2]);
   assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Write wins over read when both are offered in IDLE; nothing is accepted during reset.
   always_comb begin
      state_nxt = state;
      wr_take   = 1'b0;
      rd_take   = 1'b0;
      case (state)
         IDLE: begin
            if (!reset) begin
               if (s.s_awvalid && s.s_wvalid) begin
                  wr_take   = 1'b1;
                  state_nxt = WR_RESP;
               end else if (s.s_arvalid) begin
                  rd_take   = 1'b1;
                  state_nxt = RD_ISSUE;
               end
            end
         end
         WR_RESP:    if (s.s_bready) state_nxt = IDLE;
         RD_ISSUE:   state_nxt = RD_CAPTURE;
         RD_CAPTURE: state_nxt = RD_RESP;
         RD_RESP:    if (s.s_rready) state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   assign s.s_awready = wr_take;
   assign s.s_wready  = wr_take;
   assign s.s_arready = rd_take;
   assign s.s_bvalid  = (state == WR_RESP);
   assign s.s_rvalid  = (state == RD_RESP);
   assign s.s_bresp   = bresp;
   assign s.s_rresp   = rresp;
   assign s.s_rdata   = rdata;

`ifdef PROC_LOADER_CTRL_EN
   logic ctrl;

   always_ff @(posedge clk) begin
      if (reset)
         ctrl <= 1'b1;
      else if (wr_take && aw_region == REG_CTRL && s.s_wstrb[0])
         ctrl <= s.s_wdata[0];
   end

   assign core_reset = reset | ctrl;
`else
   assign core_reset = reset;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_in        <= '0;
         instr_wr_addr   <= '0;
         instr_wr_en     <= 1'b0;
         dmem_data_in    <= '0;
         dmem_word_addr  <= '0;
         dmem_byte_wr_en <= '0;
         bresp           <= RESP_OKAY;
         rresp           <= RESP_OKAY;
         rdata           <= '0;
         rd_region       <= REG_DMEM;
      end else begin
         // Strobes live for the single cycle after the handshake.
         instr_wr_en     <= 1'b0;
         dmem_byte_wr_en <= '0;
         if (wr_take) begin
            case (aw_region)
               REG_DMEM: begin
                  dmem_byte_wr_en <= s.s_wstrb;
                  dmem_data_in    <= wr_lanes;
                  dmem_word_addr  <= awaddr[LOGSIZE+1:2];
                  bresp           <= RESP_OKAY;
               end
               REG_IMEM: begin
                  if (s.s_wstrb == '1) begin
                     instr_wr_en   <= 1'b1;
                     instr_wr_addr <= {awaddr[LOGSIZE+1:2], 2'b00};
                     instr_in      <= wr_lanes;
                     bresp         <= RESP_OKAY;
                  end else begin
                     bresp         <= RESP_SLVERR;
                  end
               end
`ifdef PROC_LOADER_CTRL_EN
               REG_CTRL: bresp <= RESP_OKAY;
`endif
               default:  bresp <= RESP_SLVERR;
            endcase
         end
         if (rd_take) begin
            rd_region <= ar_region;
            if (ar_region == REG_DMEM) dmem_word_addr <= araddr[LOGSIZE+1:2];
         end
         if (state == RD_CAPTURE) begin
            case (rd_region)
               REG_DMEM: begin
                  rdata <= dmem_data_out;
                  rresp <= RESP_OKAY;
               end
`ifdef PROC_LOADER_CTRL_EN
               REG_CTRL: begin
                  rdata <= {{(WIDTH-1){1'b0}}, ctrl};
                  rresp <= RESP_OKAY;
               end
`endif
               default: begin
                  rdata <= '0;
                  rresp <= RESP_SLVERR;
               end
            endcase
         end
      end
   end
endmodule
